// File: rtl/truth_table_extractor_pkg.sv
// Shared types and sizing helpers for the truth-table extractor.
// No logic; imported by the extractor top and its nibble serializer.
// Optional popcount build is controlled by TT_POPCOUNT_EN in the top.
package truth_table_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        EMIT
    } state_t;

    function automatic int TT_W(input int n_in);
        return 1 << n_in;
    endfunction

    // A 2-input table is only 4 bits, so it still occupies one whole nibble.
    function automatic int NIB_CNT(input int n_in);
        return (n_in > 2) ? (1 << (n_in - 2)) : 1;
    endfunction

endpackage

// File: rtl/truth_table_extractor_nibble_serializer.sv
// Purpose: streams a held truth table as hex nibbles, MSB first.
// Latency: first nibble valid the cycle en rises; one nibble per handshake.
// Backpressure: nibble/last held stable while tt_ready is low; no timeout.
module tt_nibble_serializer
    import truth_table_pkg::*;
#(
    parameter int N_IN = 7
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [TT_W(N_IN)-1:0]  tt,
    input  logic                   tt_ready,
    output logic                   tt_valid,
    output logic [NIBBLE_W-1:0]    tt_nibble,
    output logic                   tt_last,
    output logic                   final_hs
);

    localparam int TTW  = TT_W(N_IN);
    localparam int NIBS = NIB_CNT(N_IN);
    localparam int TW   = $clog2(TTW);
    localparam int NW   = (TW > 2) ? TW - 2 : 1;

    logic [NW-1:0] n;
    logic [TW-1:0] base;
    logic          hs;

    // Top bit of nibble n is TTW-1-4n, which in TW bits is simply {~n, 2'b11}.
    generate
        if (TW > 2) begin : g_multi
            assign base = {~n, 2'b11};
        end else begin : g_single
            assign base = 2'b11;
        end
    endgenerate

    assign tt_valid  = en;
    assign hs        = en && tt_ready;
    assign tt_last   = en && (n == NW'(NIBS - 1));
    assign final_hs  = hs && tt_last;
    assign tt_nibble = en ? tt[base -: NIBBLE_W] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            n <= '0;
        end else if (hs) begin
            n <= n + 1'b1;
        end
    end

endmodule

// File: rtl/truth_table_extractor.sv
// Purpose: sweeps all input patterns into a FUT and streams its truth table; TT_POPCOUNT_EN adds ones_count/balanced.
// Latency: TT_W*(SETTLE+1) cycles of sweep after start, then one nibble per handshake.
// Backpressure: emission stalls indefinitely on tt_ready low; start ignored unless idle.
module truth_table_extractor
    import truth_table_pkg::*;
#(
    parameter int N_IN   = 7,
    parameter int SETTLE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic [N_IN-1:0]     x_out,
    input  logic                f_in,
    output logic                tt_valid,
    input  logic                tt_ready,
    output logic [NIBBLE_W-1:0] tt_nibble,
    output logic                tt_last,
    output logic                done
`ifdef TT_POPCOUNT_EN
    ,
    output logic [N_IN:0]       ones_count,
    output logic                balanced
`endif
);

    localparam int TTW = TT_W(N_IN);
    localparam int SW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam state_t PAT_ST = (SETTLE > 0) ? DRIVE : SAMPLE;

    state_t          state;
    state_t          state_nxt;
    logic [N_IN-1:0] p;
    logic [SW-1:0]   scnt;
    logic [TTW-1:0]  tt;
    logic            settle_done;
    logic            final_hs;

    assign settle_done = (scnt == SW'(SETTLE - 1));
    assign busy        = (state != IDLE);
    assign x_out       = p;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = PAT_ST;
            DRIVE:   if (settle_done) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = (&p) ? EMIT : PAT_ST;
            EMIT:    if (final_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // p doubles as the driven pattern; it parks at all-ones through EMIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p    <= '0;
            scnt <= '0;
            tt   <= '0;
            done <= 1'b0;
        end else begin
            done <= final_hs;
            case (state)
                DRIVE:   scnt <= settle_done ? '0 : scnt + 1'b1;
                SAMPLE: begin
                    tt[p] <= f_in;
                    if (!(&p)) p <= p + 1'b1;
                end
                EMIT:    if (final_hs) p <= '0;
                default: ;
            endcase
        end
    end

`ifdef TT_POPCOUNT_EN
    localparam logic [N_IN:0] HALF = {2'b01, {(N_IN - 1){1'b0}}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ones_count <= '0;
        end else if (state == IDLE && start) begin
            ones_count <= '0;
        end else if (state == SAMPLE && f_in) begin
            ones_count <= ones_count + 1'b1;
        end
    end

    assign balanced = (ones_count == HALF);
`endif

    tt_nibble_serializer #(
        .N_IN(N_IN)
    ) u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (state == EMIT),
        .tt        (tt),
        .tt_ready  (tt_ready),
        .tt_valid  (tt_valid),
        .tt_nibble (tt_nibble),
        .tt_last   (tt_last),
        .final_hs  (final_hs)
    );

endmodule

// File: doc/truth_table_extractor.md
Name: truth_table_extractor

Overview:
- Sequential truth-table extractor for 7-input single-output logic functions. It is the inverse of the classification netlists, which build a function from its truth table.
- Sweeps all 2^N_IN input patterns into an external combinational or pipelined function under test (FUT) and samples its output each time.
- Assembles the 2^N_IN-bit truth table and streams it as hex nibbles, MSB first. This is the same order as the classification hex-string naming.
- Used on the verification/characterisation side to recover a function's class key from a synthesised netlist.

Parameters:
- N_IN, 7, number of FUT inputs; legal range 2..7; truth table width TT_W = 2^N_IN.
- SETTLE, 0, FUT latency in cycles between driving x_out and sampling f_in; 0 = purely combinational FUT.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a sweep when idle.
- busy  output  1  high from the cycle after an accepted start until the last nibble handshake.
- x_out  output  N_IN  pattern driven to FUT; bit k drives FUT input xk.
- f_in  input  1  FUT output.
- tt_valid  output  1  nibble stream valid.
- tt_ready  input  1  nibble stream ready.
- tt_nibble  output  4  hex digit, MSB-first.
- tt_last  output  1  high with the final nibble.
- done  output  1  one-cycle pulse on the cycle after the final handshake.

Behaviour:
- Reset (rst_n=0 at a clock edge): all outputs go to 0. This covers busy, x_out, tt_valid, tt_nibble, tt_last and done. State returns to IDLE; pattern counter, settle counter and truth-table register are cleared.
- Reset mid-sweep or mid-emit aborts immediately. No partial nibbles are emitted afterwards.
- State machine: IDLE -> DRIVE -> SAMPLE -> (DRIVE | EMIT) -> IDLE.
- IDLE:
  - start=1 -> x_out=0, pattern counter p=0, go to DRIVE (SETTLE>0) or SAMPLE (SETTLE=0).
  - start while not IDLE is ignored.
- DRIVE: hold x_out=p for SETTLE cycles, then go to SAMPLE.
- SAMPLE:
  - tt[p] <= f_in.
  - If p = TT_W-1, go to EMIT. Otherwise p <= p+1, x_out <= p+1, go back to DRIVE/SAMPLE.
  - No wrap-around: the counter stops at TT_W-1.
- Sweep length: exactly TT_W*(SETTLE+1) cycles from leaving IDLE to entering EMIT.
- x_out holds its last pattern (all ones) during EMIT and returns to 0 in IDLE.
- EMIT:
  - Nibble index n runs 0..TT_W/4-1; tt_nibble = tt[TT_W-1-4n -: 4].
  - For N_IN=2, a single nibble is emitted.
  - tt_valid high throughout EMIT.
  - tt_nibble and tt_last are stable while tt_valid=1 and tt_ready=0.
  - Advance only on a valid&&ready handshake.
  - tt_last=1 exactly when n = TT_W/4-1.
  - The final handshake drops tt_valid and busy and returns to IDLE. done pulses high for one cycle after that handshake.
  - start asserted in the same cycle as the final handshake is ignored.
- tt_ready held low indefinitely: block waits forever in EMIT with no timeout.
- f_in is never sampled outside SAMPLE.

Optional Feature:
- Macro TT_POPCOUNT_EN.
- Defined:
  - Adds output ones_count [N_IN:0] = number of 1s in the truth table.
  - It accumulates in SAMPLE, is valid from entry to EMIT until the next accepted start, and resets to 0.
  - Adds output balanced = (ones_count == TT_W/2), with the same validity.
- Undefined: neither port exists and no counter is built. All other behaviour is identical.

Decomposition:
- Package truth_table_pkg holds:
  - state enum {IDLE, DRIVE, SAMPLE, EMIT};
  - localparam functions TT_W(N_IN) and NIB_CNT(N_IN);
  - the NIBBLE_W=4 constant.
- One sub-module, tt_nibble_serializer: takes the TT_W-bit register and runs the valid/ready/last nibble emission. The parent keeps the FSM and the sweep.

Test Plan:
- FUT f=x0, SETTLE=0, tt_ready=1 -> 32 nibbles all 'a'; tt_last on 32nd; done one cycle later; sweep takes 128 cycles.
- FUT f=x6, SETTLE=2 -> nibbles 0..15 'f', 16..31 '0'; sweep takes 384 cycles; x_out holds each pattern 3 cycles.
- FUT f=XOR(x0..x6) with random tt_ready backpressure -> stream begins "9669", never changes while stalled, exactly 32 handshakes.
- Reset asserted at pattern 57 -> next cycle all outputs 0, state IDLE. A new start then yields a correct full stream for f=x0.
- start pulsed during DRIVE/SAMPLE/EMIT and in the final-handshake cycle -> ignored; exactly one stream per accepted start.
- With TT_POPCOUNT_EN, FUT f=MAJ(x0,x3,x5) -> ones_count=64, balanced=1. With f=AND(x0,x1) -> ones_count=32, balanced=0.
